// File: rtl/s382_bist_pkg.sv
// -----------------------------------------------------------------------------
// s382_bist_pkg
// Shared definitions for the s382 BIST slice: compactor FSM states, the default
// response/signature widths, the default MISR polynomial and seed, and the MISR
// step function. The step function is shared by the RTL and the bench models.
// -----------------------------------------------------------------------------
package s382_bist_pkg;

    localparam int SIG_W  = 16;
    localparam int RESP_W = 6;

    // x^16 + x^5 + x^3 + x^2 + 1, Galois form (x^16 term implied by the shift-out).
    localparam logic [SIG_W-1:0] DEF_POLY = 16'h002D;
    localparam logic [SIG_W-1:0] DEF_SEED = 16'h0000;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SKIP    = 2'd1,
        ST_COMPACT = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    // One MISR step: shift left, fold the polynomial in when the MSB falls out,
    // then XOR in the zero-extended response word.
    function automatic logic [SIG_W-1:0] misr_step(
        input logic [SIG_W-1:0]  sig,
        input logic [RESP_W-1:0] resp,
        input logic [SIG_W-1:0]  poly
    );
        logic [SIG_W-1:0] fb;
        fb = sig[SIG_W-1] ? poly : '0;
        return {sig[SIG_W-2:0], 1'b0} ^ fb ^ {{(SIG_W-RESP_W){1'b0}}, resp};
    endfunction

endpackage

// File: rtl/s382_misr.sv
// -----------------------------------------------------------------------------
// s382_misr
// 16-bit multiple-input signature register.
// Ports:
//   clk      - clock, rising edge
//   rst      - synchronous active-high reset, clears the signature
//   load     - load seed this cycle (priority over en)
//   seed     - value loaded by load
//   en       - apply one MISR step with resp this cycle
//   resp     - response word folded in by a step
//   sig      - registered signature
//   sig_next - value the register would take on a step (used for the
//              end-of-run compare so PASS lines up with the final SIG)
// -----------------------------------------------------------------------------
module s382_misr
    import s382_bist_pkg::*;
#(
    parameter int               SIG_W  = s382_bist_pkg::SIG_W,
    parameter int               RESP_W = s382_bist_pkg::RESP_W,
    parameter logic [SIG_W-1:0] POLY   = s382_bist_pkg::DEF_POLY
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [SIG_W-1:0]  seed,
    input  logic              en,
    input  logic [RESP_W-1:0] resp,
    output logic [SIG_W-1:0]  sig,
    output logic [SIG_W-1:0]  sig_next
);

    // NOTE: combinational block assigns its output unconditionally, so no latch can form.
    always_comb begin
        sig_next = misr_step(sig, resp, POLY);
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            sig <= '0;
        end else if (load) begin
            sig <= seed;
        end else if (en) begin
            sig <= sig_next;
        end
    end

endmodule

// File: rtl/s382_resp_compactor.sv
// -----------------------------------------------------------------------------
// s382_resp_compactor
// Output-side response compactor for the s382 core. Discards SKIP leading valid
// responses, folds LEN responses into a MISR, then compares with EXP_SIG.
// Ports:
//   CK         - clock, rising edge
//   RST        - synchronous active-high reset
//   START      - run request, only honoured in IDLE
//   LEN        - responses to compact (latched with START)
//   SKIP       - leading valid responses to discard (latched with START)
//   EXP_SIG    - expected signature (latched with START)
//   RESP_VALID - RESP is valid this cycle
//   RESP       - core response word (G301 = bit 0)
//   BUSY       - run in progress (SKIP or COMPACT)
//   DONE       - one-cycle end-of-run pulse
//   PASS       - last run result, held until the next accepted START
//   SIG        - current signature
// All outputs are registered.
// -----------------------------------------------------------------------------
module s382_resp_compactor
    import s382_bist_pkg::*;
#(
    parameter int               RESP_W = s382_bist_pkg::RESP_W,
    parameter int               SIG_W  = s382_bist_pkg::SIG_W,
    parameter logic [SIG_W-1:0] POLY   = s382_bist_pkg::DEF_POLY,
    parameter logic [SIG_W-1:0] SEED   = s382_bist_pkg::DEF_SEED
) (
    input  logic              CK,
    input  logic              RST,
    input  logic              START,
    input  logic [15:0]       LEN,
    input  logic [7:0]        SKIP,
    input  logic [SIG_W-1:0]  EXP_SIG,
    input  logic              RESP_VALID,
    input  logic [RESP_W-1:0] RESP,
    output logic              BUSY,
    output logic              DONE,
    output logic              PASS,
    output logic [SIG_W-1:0]  SIG
);

    state_t           state;
    logic [7:0]       skip_cnt;
    logic [15:0]      len_cnt;
    logic [SIG_W-1:0] exp_sig_q;
    logic [SIG_W-1:0] sig_next;
    logic             misr_load;
    logic             misr_en;

    assign misr_load = (state == ST_IDLE) && START;
    assign misr_en   = (state == ST_COMPACT) && RESP_VALID;

    s382_misr #(
        .SIG_W  (SIG_W),
        .RESP_W (RESP_W),
        .POLY   (POLY)
    ) u_misr (
        .clk      (CK),
        .rst      (RST),
        .load     (misr_load),
        .seed     (SEED),
        .en       (misr_en),
        .resp     (RESP),
        .sig      (SIG),
        .sig_next (sig_next)
    );

    always_ff @(posedge CK) begin
        if (RST) begin
            // NOTE: the latched expected signature is reset too, so no value from an aborted run survives.
            state     <= ST_IDLE;
            skip_cnt  <= '0;
            len_cnt   <= '0;
            exp_sig_q <= '0;
            BUSY      <= 1'b0;
            DONE      <= 1'b0;
            PASS      <= 1'b0;
        end else begin
            DONE <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (START) begin
                        skip_cnt  <= SKIP;
                        len_cnt   <= LEN;
                        exp_sig_q <= EXP_SIG;
                        PASS      <= 1'b0;
                        if (LEN == 16'd0) begin
                            // Nothing to compact: the seed is the final signature.
                            state <= ST_DONE;
                            DONE  <= 1'b1;
                            PASS  <= (SEED == EXP_SIG);
                            BUSY  <= 1'b0;
                        end else begin
                            state <= (SKIP != 8'd0) ? ST_SKIP : ST_COMPACT;
                            BUSY  <= 1'b1;
                        end
                    end
                end
                ST_SKIP: begin
                    if (RESP_VALID) begin
                        skip_cnt <= skip_cnt - 8'd1;
                        if (skip_cnt == 8'd1) begin
                            state <= ST_COMPACT;
                        end
                    end
                end
                ST_COMPACT: begin
                    if (RESP_VALID) begin
                        len_cnt <= len_cnt - 16'd1;
                        if (len_cnt == 16'd1) begin
                            // Compare against the value SIG takes on this same edge.
                            state <= ST_DONE;
                            BUSY  <= 1'b0;
                            DONE  <= 1'b1;
                            PASS  <= (sig_next == exp_sig_q);
                        end
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_s382_resp_compactor.sv
// -----------------------------------------------------------------------------
// tb_s382_resp_compactor
// Self-checking bench. Two compactor instances share all inputs: one with the
// default seed 0 and one with seed 16'h8000 so the feedback tap is exercised.
// The reference is transaction level: it walks the list of valid responses,
// drops the first SKIP of them and folds the rest with the MISR arithmetic.
// -----------------------------------------------------------------------------
module tb_s382_resp_compactor;

    localparam logic [15:0] POLY  = 16'h002D;
    localparam logic [15:0] SEED0 = 16'h0000;
    localparam logic [15:0] SEED1 = 16'h8000;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        start;
    logic [15:0] len;
    logic [7:0]  skip;
    logic [15:0] exp_sig;
    logic        resp_valid;
    logic [5:0]  resp;

    logic        busy0, done0, pass0;
    logic [15:0] sig0;
    logic        busy1, done1, pass1;
    logic [15:0] sig1;

    s382_resp_compactor #(.SEED(SEED0)) u_dut0 (
        .CK(clk), .RST(rst), .START(start), .LEN(len), .SKIP(skip),
        .EXP_SIG(exp_sig), .RESP_VALID(resp_valid), .RESP(resp),
        .BUSY(busy0), .DONE(done0), .PASS(pass0), .SIG(sig0)
    );

    s382_resp_compactor #(.SEED(SEED1)) u_dut1 (
        .CK(clk), .RST(rst), .START(start), .LEN(len), .SKIP(skip),
        .EXP_SIG(exp_sig), .RESP_VALID(resp_valid), .RESP(resp),
        .BUSY(busy1), .DONE(done1), .PASS(pass1), .SIG(sig1)
    );

    int total = 0;
    int bad   = 0;

    logic [15:0] seeds [2];
    logic        exp_pass [2];
    logic [5:0]  stim_q [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h (t=%0t)", tag, got, want, $time);
        end
    endtask

    // Reference MISR step written as plain arithmetic on the integer value.
    function automatic logic [15:0] ref_step(input logic [15:0] s, input logic [5:0] r);
        int t;
        t = 2 * int'(s);
        if (t > 'hFFFF) t = (t - 'h10000) ^ int'(POLY);
        t = t ^ int'(r);
        return t[15:0];
    endfunction

    function automatic logic [15:0] model_final(input logic [15:0] seed, input int n_skip,
                                                input logic [5:0] q [$]);
        logic [15:0] s;
        s = seed;
        for (int i = n_skip; i < q.size(); i++) s = ref_step(s, q[i]);
        return s;
    endfunction

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic expect_all(input string tag, input logic eb, input logic ed,
                              input logic [15:0] es0, input logic [15:0] es1);
        check({tag, ".busy0"}, busy0, eb);
        check({tag, ".done0"}, done0, ed);
        check({tag, ".pass0"}, pass0, exp_pass[0]);
        check({tag, ".sig0"},  sig0,  es0);
        check({tag, ".busy1"}, busy1, eb);
        check({tag, ".done1"}, done1, ed);
        check({tag, ".pass1"}, pass1, exp_pass[1]);
        check({tag, ".sig1"},  sig1,  es1);
    endtask

    // One run. Responses come from stim_q when it holds data, else random.
    // poke: pulse START during the second response gap and during DONE.
    // rst_after: assert RST after that many valid responses (-1 = never).
    task automatic do_run(input string name, input int n_len, input int n_skip,
                          input logic [15:0] exp, input int min_gap, input int max_gap,
                          input bit poke, input int rst_after);
        logic [15:0] m [2];
        logic [5:0]  r;
        int          gap;
        bit          last;

        start   = 1'b1;
        len     = 16'(n_len);
        skip    = 8'(n_skip);
        exp_sig = exp;
        tick();
        start   = 1'b0;
        // Scramble the sampled-with-START inputs to show they were latched.
        len     = 16'($urandom);
        skip    = 8'($urandom);
        exp_sig = 16'($urandom);
        m[0] = seeds[0];
        m[1] = seeds[1];

        if (n_len == 0) begin
            exp_pass[0] = (seeds[0] == exp);
            exp_pass[1] = (seeds[1] == exp);
            expect_all({name, ".zlen_done"}, 1'b0, 1'b1, m[0], m[1]);
            resp_valid = 1'b1;
            resp = 6'($urandom);
            tick();
            resp_valid = 1'b0;
            expect_all({name, ".zlen_idle"}, 1'b0, 1'b0, m[0], m[1]);
            return;
        end

        exp_pass[0] = 1'b0;
        exp_pass[1] = 1'b0;
        expect_all({name, ".start"}, 1'b1, 1'b0, m[0], m[1]);

        for (int k = 0; k < n_skip + n_len; k++) begin
            gap = int'($urandom_range(max_gap, min_gap));
            if (poke && k == 1 && gap == 0) gap = 1;
            for (int g = 0; g < gap; g++) begin
                if (poke && k == 1 && g == 0) begin
                    start = 1'b1;
                    len   = 16'd1;
                    skip  = 8'd0;
                end
                resp = 6'($urandom);
                tick();
                start = 1'b0;
                expect_all({name, ".gap"}, 1'b1, 1'b0, m[0], m[1]);
            end

            r = (stim_q.size() != 0) ? stim_q.pop_front() : 6'($urandom);
            resp_valid = 1'b1;
            resp       = r;
            tick();
            resp_valid = 1'b0;
            resp       = 6'($urandom);
            if (k >= n_skip) begin
                m[0] = ref_step(m[0], r);
                m[1] = ref_step(m[1], r);
            end
            last = (k == n_skip + n_len - 1);
            if (last) begin
                exp_pass[0] = (m[0] == exp);
                exp_pass[1] = (m[1] == exp);
            end
            expect_all({name, last ? ".last" : ".step"}, !last, last, m[0], m[1]);

            if (rst_after == k + 1) begin
                rst = 1'b1;
                tick();
                rst = 1'b0;
                exp_pass[0] = 1'b0;
                exp_pass[1] = 1'b0;
                expect_all({name, ".rst"}, 1'b0, 1'b0, 16'h0000, 16'h0000);
                for (int j = 0; j < 3; j++) begin
                    resp_valid = 1'b1;
                    resp = 6'($urandom);
                    tick();
                    resp_valid = 1'b0;
                    expect_all({name, ".rst_idle"}, 1'b0, 1'b0, 16'h0000, 16'h0000);
                end
                stim_q.delete();
                return;
            end
        end

        // Currently in the DONE cycle.
        if (poke) begin
            start = 1'b1;
            len   = 16'd5;
            skip  = 8'd0;
        end
        resp_valid = 1'b1;
        resp = 6'($urandom);
        tick();
        start = 1'b0;
        resp_valid = 1'b0;
        expect_all({name, ".idle"}, 1'b0, 1'b0, m[0], m[1]);
    endtask

    // Fill stim_q with random words and return an expected signature that
    // matches one of the two instances, or neither.
    task automatic prep_random(input int n_len, input int n_skip, output logic [15:0] exp);
        int sel;
        stim_q.delete();
        for (int i = 0; i < n_skip + n_len; i++) stim_q.push_back(6'($urandom));
        sel = int'($urandom_range(2, 0));
        if (sel == 0)      exp = model_final(seeds[0], n_skip, stim_q);
        else if (sel == 1) exp = model_final(seeds[1], n_skip, stim_q);
        else               exp = 16'($urandom);
    endtask

    initial begin
        logic [15:0] e;
        int          nl, ns;

        seeds[0]    = SEED0;
        seeds[1]    = SEED1;
        exp_pass[0] = 1'b0;
        exp_pass[1] = 1'b0;
        rst        = 1'b1;
        start      = 1'b0;
        len        = '0;
        skip       = '0;
        exp_sig    = '0;
        resp_valid = 1'b0;
        resp       = '0;
        @(negedge clk);
        tick();
        expect_all("reset", 1'b0, 1'b0, 16'h0000, 16'h0000);
        rst = 1'b0;
        tick();
        expect_all("reset_idle", 1'b0, 1'b0, 16'h0000, 16'h0000);

        // Basic run: SIG 1, 2, 4 on the seed-0 instance.
        stim_q = '{6'h01, 6'h00, 6'h00};
        do_run("basic", 3, 0, 16'h0004, 0, 0, 1'b0, -1);
        check("basic.pass0_final", pass0, 1'b1);

        // Feedback tap: seed 8000 with a zero response gives POLY.
        stim_q = '{6'h00};
        do_run("tap", 1, 0, 16'h0000, 0, 0, 1'b0, -1);
        check("tap.sig1", sig1, 16'h002D);

        // Skip and stall, three idle cycles before each valid.
        stim_q = '{6'h3F, 6'h3F, 6'h05};
        do_run("skip", 1, 2, 16'h0005, 3, 3, 1'b0, -1);
        check("skip.sig0", sig0, 16'h0005);

        // Zero length: immediate DONE, no skip phase.
        do_run("zlen", 0, 5, 16'h0000, 0, 0, 1'b0, -1);

        // START during COMPACT and during DONE, then back-to-back run.
        prep_random(4, 0, e);
        do_run("proto", 4, 0, e, 1, 2, 1'b1, -1);
        prep_random(3, 1, e);
        do_run("b2b", 3, 1, e, 0, 0, 1'b0, -1);

        // Reset mid-run, then a normal run.
        do_run("rst", 10, 0, 16'h1234, 0, 1, 1'b0, 2);
        prep_random(5, 2, e);
        do_run("after_rst", 5, 2, e, 0, 2, 1'b0, -1);

        // Counter width boundary: full 8-bit skip and a length above 255.
        prep_random(260, 255, e);
        do_run("wide", 260, 255, e, 0, 0, 1'b0, -1);

        // Randomised runs.
        for (int i = 0; i < 10; i++) begin
            nl = int'($urandom_range(20, 0));
            ns = int'($urandom_range(4, 0));
            prep_random(nl, ns, e);
            do_run("rand", nl, ns, e, 0, 2, 1'b0, -1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
